// File: rtl/nn_param_loader.sv
// Streaming parameter loader: assembles NEURONS*(M+1) stream words into a shadow
// bank and commits it atomically to the layer's weight/bias ports on a well-framed transfer.
module nn_param_loader #(
  parameter int NEURONS = 2,
  parameter int M       = 11,
  parameter int W       = 8,
  parameter int B       = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic                    run_en,
  output logic [NEURONS*M*W-1:0]  weights,
  output logic [NEURONS*B-1:0]    biases,
  output logic                    load_params,
  output logic                    params_ok,
  output logic                    commit,
  output logic                    frame_err,
  output logic [1:0]              state_dbg
);

  localparam int PW = $clog2(M + 1);
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic [PW-1:0] POS_LAST  = PW'(M);
  localparam logic [NW-1:0] NIDX_LAST = NW'(NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]            pos;
  logic [NW-1:0]            nidx;
  logic [NEURONS*M*W-1:0]   shadow_w;
  logic [NEURONS*B-1:0]     shadow_b;

  logic ready_st;
  logic xfer;
  logic last_slot;
  logic shadow_we;
  logic err_set;
  logic cnt_clr;
  logic cnt_inc;
  logic do_commit;

  // Handshake: a word transfers on a rising edge where s_valid and s_ready are both high;
  // s_valid may drop at any time and the loader holds state and counters while it is low.
  assign s_ready   = rstn & ready_st;
  assign xfer      = s_valid & s_ready;
  assign last_slot = (nidx == NIDX_LAST) && (pos == POS_LAST);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          if (last_slot)   state_nxt = s_last ? COMMIT : DRAIN;
          else if (s_last) state_nxt = IDLE;
          else             state_nxt = LOAD;
        end
      end
      COMMIT:  state_nxt = IDLE;
      DRAIN:   if (xfer && s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_st  = (state != COMMIT);
    shadow_we = ((state == IDLE) || (state == LOAD)) && xfer;
    // Error when s_last disagrees with the slot position: early, or missing on the final word.
    err_set   = shadow_we && (last_slot ? !s_last : s_last);
    cnt_clr   = (shadow_we && (last_slot || s_last)) || (state == COMMIT);
    cnt_inc   = shadow_we && !cnt_clr;
    do_commit = (state == COMMIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos  <= '0;
      nidx <= '0;
    end else if (cnt_clr) begin
      pos  <= '0;
      nidx <= '0;
    end else if (cnt_inc) begin
      if (pos == POS_LAST) begin
        pos  <= '0;
        nidx <= nidx + 1'b1;
      end else begin
        pos  <= pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_w <= '0;
      shadow_b <= '0;
    end else begin
      for (int j = 0; j < NEURONS; j++) begin
        for (int p = 0; p < M; p++) begin
          if (shadow_we && (nidx == NW'(j)) && (pos == PW'(p)))
            shadow_w[(j*M+p)*W +: W] <= s_data[W-1:0];
        end
        if (shadow_we && (nidx == NW'(j)) && (pos == POS_LAST))
          shadow_b[j*B +: B] <= s_data[B-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weights   <= '0;
      biases    <= '0;
      params_ok <= 1'b0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      commit    <= do_commit;
      frame_err <= err_set;
      if (do_commit) begin
        weights   <= shadow_w;
        biases    <= shadow_b;
        params_ok <= 1'b1;
      end
    end
  end

  assign load_params = params_ok & run_en;

endmodule

// File: tb/tb_nn_param_loader.sv
// Bench for nn_param_loader: good, gapped, malformed, back-to-back and reset-interrupted
// frames, with committed banks checked against a queue of expected banks.
module tb_nn_param_loader;

  localparam int NEURONS = 2;
  localparam int M       = 11;
  localparam int W       = 8;
  localparam int B       = 8;
  localparam int FL      = NEURONS * (M + 1);
  localparam int WT      = NEURONS * M * W;
  localparam int BT      = NEURONS * B;
  localparam int XT      = WT + BT;

  logic           clk;
  logic           rstn;
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic           run_en;
  logic [WT-1:0]  weights;
  logic [BT-1:0]  biases;
  logic           load_params;
  logic           params_ok;
  logic           commit;
  logic           frame_err;
  logic [1:0]     state_dbg;

  nn_param_loader #(.NEURONS(NEURONS), .M(M), .W(W), .B(B)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .run_en      (run_en),
    .weights     (weights),
    .biases      (biases),
    .load_params (load_params),
    .params_ok   (params_ok),
    .commit      (commit),
    .frame_err   (frame_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [XT-1:0] exp_q[$];
  logic [XT-1:0] model_act = '0;
  int checks = 0;
  int errors = 0;
  int obs_commits = 0;
  int obs_errs = 0;
  int exp_errs = 0;
  int last_commit_cyc = 0;
  int stall = 0;
  int first_stall = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (commit) begin
        obs_commits++;
        last_commit_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", commit, 1'b0);
        end else begin
          model_act = exp_q.pop_front();
          check("commit_data", {biases, weights}, model_act);
        end
      end
      if (frame_err) obs_errs++;
    end
  end

  // driver tasks
  task automatic send_word(input logic [7:0] d, input bit last);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stall = n;
    if (n >= 50) check("s_ready_timeout", s_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind 0: word i = i+1, kind 1: all fill, kind 2: random
  task automatic send_good(input int kind, input logic [7:0] fill, input int ngaps, input bit chk_lat);
    logic [7:0]    d[FL];
    int            gap[FL];
    logic [XT-1:0] e;
    int            first;
    int            j;
    int            p;
    e = '0;
    first = 0;
    for (int i = 0; i < FL; i++) begin
      d[i]   = (kind == 0) ? 8'(i + 1) : (kind == 1) ? fill : 8'($urandom_range(0, 255));
      gap[i] = 0;
      j = i / (M + 1);
      p = i % (M + 1);
      if (p < M) e[(j*M+p)*W +: W] = d[i];
      else       e[WT + j*B +: B]  = d[i];
    end
    for (int k = 0; k < ngaps; k++) gap[$urandom_range(1, FL - 1)]++;
    exp_q.push_back(e);
    for (int i = 0; i < FL; i++) begin
      if (gap[i] > 0) begin
        s_valid = 1'b0;
        repeat (gap[i]) @(negedge clk);
      end
      send_word(d[i], i == FL - 1);
      if (i == 0) begin
        first = cyc;
        first_stall = stall;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      #1;
      check("commit_latency", last_commit_cyc - first, FL + ngaps);
    end
  endtask

  task automatic send_seq(input int n, input int last_at, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_word(8'(base + i), i == last_at);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    int budget;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    run_en  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_weights", weights, '0);
    check("rst_biases", biases, '0);
    check("rst_params_ok", params_ok, 1'b0);
    check("rst_load_params", load_params, 1'b0);
    check("rst_commit", commit, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    rstn = 1'b1;
    #1;
    check("ready_after_rst", s_ready, 1'b1);
    check("idle_after_rst", state_dbg, 2'd0);
    @(negedge clk);

    // basic frame, then run_en gating
    send_good(0, 8'h00, 0, 1'b1);
    check("params_ok_set", params_ok, 1'b1);
    check("load_params_off", load_params, 1'b0);
    run_en = 1'b1;
    #1;
    check("load_params_on", load_params, 1'b1);

    // same frame with three idle cycles inside
    send_good(0, 8'h00, 3, 1'b1);

    // early s_last on word 10
    send_seq(11, 10, 8'h40);
    exp_errs++;
    repeat (2) @(negedge clk);
    check("early_err_count", obs_errs, exp_errs);
    check("early_hold_out", {biases, weights}, model_act);
    check("early_params_ok", params_ok, 1'b1);
    check("early_no_commit", obs_commits, 2);
    send_good(2, 8'h00, 0, 1'b1);

    // missing s_last on final word, five drain words
    send_seq(FL + 5, FL + 4, 8'h80);
    exp_errs++;
    repeat (2) @(negedge clk);
    check("drain_err_count", obs_errs, exp_errs);
    check("drain_no_commit", obs_commits, 3);
    check("drain_to_idle", state_dbg, 2'd0);
    check("drain_hold_out", {biases, weights}, model_act);
    send_good(2, 8'h00, 0, 1'b1);

    // back-to-back frames
    send_good(1, 8'h55, 0, 1'b0);
    check("b2b_bubble", s_ready, 1'b0);
    send_good(1, 8'hAA, 0, 1'b1);
    check("b2b_stall", first_stall, 1);
    check("b2b_weights", weights, {(WT/8){8'hAA}});
    check("b2b_biases", biases, {(BT/8){8'hAA}});

    // reset in the middle of a frame
    send_seq(12, -1, 8'h10);
    rstn    = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_weights", weights, '0);
    check("midrst_biases", biases, '0);
    check("midrst_params_ok", params_ok, 1'b0);
    check("midrst_load_params", load_params, 1'b0);
    exp_q.delete();
    model_act = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_seq(12, 11, 8'h20);
    exp_errs++;
    repeat (2) @(negedge clk);
    check("midrst_err_count", obs_errs, exp_errs);
    check("midrst_still_zero", {biases, weights}, '0);
    check("midrst_no_ok", params_ok, 1'b0);
    send_good(0, 8'h00, 0, 1'b1);
    check("midrst_recommit_ok", params_ok, 1'b1);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("pending_commits", exp_q.size(), 0);
    check("total_errs", obs_errs, exp_errs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
